// File: rtl/obf_key_loader.sv
// Serial key loader for a MUX/camouflage-locked netlist.
// Parity-checked frames commit atomically; repeated bad frames lock out.
module obf_key_loader #(
  parameter int KEY_W    = 2,
  parameter int MAX_FAIL = 3,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             sdi,
  input  logic             sdi_vld,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_done,
  output logic             load_err,
  output logic             busy,
  output logic             locked_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_LOCK
  } state_t;

  state_t           state_q;
  logic [KEY_W-1:0] shadow_q;
  logic [KEY_W-1:0] shadow_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             par_q;
  logic [3:0]       fail_cnt_q;
  logic [3:0]       fail_cnt_d;
  logic             par_ok;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             load_done_q;
  logic             load_err_q;
  logic             busy_q;
  logic             locked_q;

  // Next shadow image, next fail count and the even-parity verdict.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < KEY_W; i++) begin
      if (bit_cnt_q == CNT_W'(i)) begin
        shadow_d[i] = sdi;
      end
    end
    par_ok = ~(^shadow_q ^ par_q);
    if (fail_cnt_q == 4'(MAX_FAIL)) begin
      fail_cnt_d = fail_cnt_q;
    end else begin
      fail_cnt_d = fail_cnt_q + 4'd1;
    end
  end

  // Frame FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      fail_cnt_q  <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_q   <= S_SHIFT;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (frame_start) begin
            shadow_q  <= '0;
            bit_cnt_q <= '0;
          end else if (sdi_vld) begin
            if (bit_cnt_q == CNT_W'(KEY_W)) begin
              par_q   <= sdi;
              state_q <= S_CHECK;
            end else begin
              shadow_q  <= shadow_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          busy_q <= 1'b0;
          if (par_ok) begin
            key_q       <= shadow_q;
            key_valid_q <= 1'b1;
            load_done_q <= 1'b1;
            fail_cnt_q  <= '0;
            state_q     <= S_IDLE;
          end else begin
            load_err_q <= 1'b1;
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_d == 4'(MAX_FAIL)) begin
              key_q       <= '0;
              key_valid_q <= 1'b0;
              locked_q    <= 1'b1;
              state_q     <= S_LOCK;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_LOCK: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign key_out    = key_q;
  assign key_valid  = key_valid_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign busy       = busy_q;
  assign locked_out = locked_q;

endmodule
